// File: rtl/cpu_step_pkg.sv
// Shared types for the CPU single-step / run controller.
package cpu_step_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_N    = 2'd1,
        ST_RUN_FREE = 2'd2,
        ST_BP_HALT  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        OP_STEP     = 2'd0,
        OP_RUN_N    = 2'd1,
        OP_RUN_FREE = 2'd2,
        OP_HALT     = 2'd3
    } cmd_op_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debouncer for an active-low pushbutton;
// emits a one-cycle pulse when a new pressed (low) level is accepted.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw button into the clk domain (idle level is high).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: single step, counted run, free run and
// breakpoint halt, with a debounced step pushbutton.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned RUN_DIV         = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              btn_step,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_count,
    input  logic              bp_en,
    input  logic [DATA_W-1:0] bp_addr,
    input  logic [DATA_W-1:0] cpu_pc,
    output logic              cpu_clk_en,
    output logic [1:0]        ctrl_state,
    output logic [DATA_W-1:0] cycle_count,
    output logic              bp_hit
);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);

    ctrl_state_t       state_q, state_d;
    logic              pulse_q, pulse_d;
    logic [DATA_W-1:0] remain_q, remain_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              bp_hit_q, bp_hit_d;
    logic              btn_press;
    cmd_op_t           op;

    assign op = cmd_op_t'(cmd_op);

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .resetn(resetn),
        .btn   (btn_step),
        .press (btn_press)
    );

    // Next-state and pulse decision; remain_q counts pulses still owed after the current one.
    always_comb begin
        state_d  = state_q;
        pulse_d  = 1'b0;
        remain_d = remain_q;
        div_d    = div_q;
        bp_hit_d = bp_hit_q;
        case (state_q)
            ST_IDLE, ST_BP_HALT: begin
                if (cmd_valid) begin
                    case (op)
                        OP_STEP: begin
                            pulse_d  = 1'b1;
                            bp_hit_d = 1'b0;
                            state_d  = ST_IDLE;
                        end
                        OP_RUN_N: begin
                            if (cmd_count != '0) begin
                                pulse_d  = 1'b1;
                                bp_hit_d = 1'b0;
                                div_d    = DIV_RELOAD;
                                remain_d = cmd_count - DATA_W'(1);
                                state_d  = (cmd_count == DATA_W'(1)) ? ST_IDLE : ST_RUN_N;
                            end
                        end
                        OP_RUN_FREE: begin
                            pulse_d  = 1'b1;
                            bp_hit_d = 1'b0;
                            div_d    = DIV_RELOAD;
                            state_d  = ST_RUN_FREE;
                        end
                        default: begin
                            bp_hit_d = 1'b0;
                            state_d  = ST_IDLE;
                        end
                    endcase
                end else if (btn_press) begin
                    pulse_d  = 1'b1;
                    bp_hit_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN_N, ST_RUN_FREE: begin
                if (cmd_valid && (op == OP_HALT)) begin
                    state_d = ST_IDLE;
                end else if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (bp_en && (cpu_pc == bp_addr)) begin
                    state_d  = ST_BP_HALT;
                    bp_hit_d = 1'b1;
                end else begin
                    pulse_d = 1'b1;
                    div_d   = DIV_RELOAD;
                    if (state_q == ST_RUN_N) begin
                        remain_d = remain_q - DATA_W'(1);
                        if (remain_q == DATA_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pulse and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pulse_q     <= 1'b0;
            remain_q    <= '0;
            div_q       <= '0;
            bp_hit_q    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            remain_q <= remain_d;
            div_q    <= div_d;
            bp_hit_q <= bp_hit_d;
            if (pulse_d) begin
                cycle_count <= cycle_count + DATA_W'(1);
            end
        end
    end

    // CPU must see clock edges while held in reset so its own sync reset takes effect.
    assign cpu_clk_en = pulse_q | ~resetn;
    assign ctrl_state = state_q;
    assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed + randomized bench for cpu_step_ctrl with a pulse-timeline reference model.
module tb_cpu_step_ctrl;
    import cpu_step_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned DIV = 3;

    logic        clk;
    logic        resetn;
    logic        btn_step;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] cpu_pc;
    logic        cpu_clk_en;
    logic [1:0]  ctrl_state;
    logic [31:0] cycle_count;
    logic        bp_hit;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          pulses[$];
    logic        pend  = 1'b0;
    logic [31:0] exp_cnt;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_step   (btn_step),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_pc     (cpu_pc),
        .cpu_clk_en (cpu_clk_en),
        .ctrl_state (ctrl_state),
        .cycle_count(cycle_count),
        .bp_hit     (bp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: sample on the falling edge; the modelled CPU advances its PC
    // one cycle after each enabled edge, as a real CE-gated register would appear.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend) cpu_pc = cpu_pc + 32'd4;
        pend = resetn && cpu_clk_en;
        if (pend) pulses.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input cmd_op_t op, input logic [31:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_count = $urandom;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected train: n pulses, the first in cycle a, then every DIV cycles.
    task automatic check_train(input string tag, input int a, input int n);
        check({tag, "_npulse"}, 32'(pulses.size()), 32'(n));
        for (int i = 0; i < pulses.size(); i++)
            check({tag, "_tpulse"}, 32'(pulses[i]), 32'(a + i * int'(DIV)));
    endtask

    initial begin
        int a;
        int n;
        int k;
        int exp_p;
        logic be;
        logic free;
        logic halt;

        resetn    = 1'b0;
        btn_step  = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_count = 32'd0;
        bp_en     = 1'b0;
        bp_addr   = 32'd0;
        cpu_pc    = 32'd0;
        exp_cnt   = 32'd0;

        // Reset held 5 cycles: CE forced high throughout.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ce", 32'(cpu_clk_en), 32'd1);
        end
        check("rst_state", 32'(ctrl_state), 32'(ST_IDLE));
        check("rst_count", cycle_count, 32'd0);
        check("rst_bphit", 32'(bp_hit), 32'd0);
        resetn = 1'b1;
        #1;
        check("rel_ce", 32'(cpu_clk_en), 32'd0);
        tick();
        check("rel_ce2", 32'(cpu_clk_en), 32'd0);
        check("rel_state", 32'(ctrl_state), 32'(ST_IDLE));
        check("rel_count", cycle_count, 32'd0);

        // Short button glitch: rejected.
        pulses.delete();
        btn_step = 1'b0;
        ticks(3);
        btn_step = 1'b1;
        ticks(20);
        check("btn_short", 32'(pulses.size()), 32'd0);

        // Long press: exactly one pulse; release adds none.
        pulses.delete();
        btn_step = 1'b0;
        ticks(10);
        btn_step = 1'b1;
        ticks(20);
        check("btn_long", 32'(pulses.size()), 32'd1);
        exp_cnt = exp_cnt + 32'd1;
        check("btn_count", cycle_count, exp_cnt);

        // Counted run of 5.
        pulses.delete();
        send(OP_RUN_N, 32'd5);
        a = cyc;
        check("runn_state", 32'(ctrl_state), 32'(ST_RUN_N));
        ticks(20);
        check_train("runn5", a, 5);
        exp_cnt = exp_cnt + 32'd5;
        check("runn5_count", cycle_count, exp_cnt);
        check("runn5_state", 32'(ctrl_state), 32'(ST_IDLE));

        // Counted run of 0 is a no-op.
        pulses.delete();
        send(OP_RUN_N, 32'd0);
        ticks(8);
        check("runn0", 32'(pulses.size()), 32'd0);
        check("runn0_state", 32'(ctrl_state), 32'(ST_IDLE));

        // Free run into a breakpoint at 0x0C, then step off it.
        cpu_pc  = 32'd0;
        bp_en   = 1'b1;
        bp_addr = 32'h0000_000C;
        pulses.delete();
        send(OP_RUN_FREE, 32'd0);
        a = cyc;
        ticks(20);
        check_train("bp", a, 3);
        exp_cnt = exp_cnt + 32'd3;
        check("bp_count", cycle_count, exp_cnt);
        check("bp_state", 32'(ctrl_state), 32'(ST_BP_HALT));
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_pc", cpu_pc, 32'h0000_000C);
        pulses.delete();
        send(OP_STEP, 32'd0);
        a = cyc;
        ticks(4);
        check_train("bp_step", a, 1);
        exp_cnt = exp_cnt + 32'd1;
        check("bp_step_pc", cpu_pc, 32'h0000_0010);
        check("bp_step_hit", 32'(bp_hit), 32'd0);
        check("bp_step_state", 32'(ctrl_state), 32'(ST_IDLE));
        check("bp_step_count", cycle_count, exp_cnt);
        bp_en = 1'b0;

        // HALT coinciding with a debounced press during a free run.
        pulses.delete();
        send(OP_RUN_FREE, 32'd0);
        a = cyc;
        btn_step = 1'b0;
        ticks(6);
        send(OP_HALT, 32'd0);
        btn_step = 1'b1;
        check("halt_state", 32'(ctrl_state), 32'(ST_IDLE));
        ticks(12);
        check_train("halt", a, 3);
        exp_cnt = exp_cnt + 32'd3;
        check("halt_count", cycle_count, exp_cnt);

        // Command and press in the same cycle from IDLE: press discarded.
        pulses.delete();
        btn_step = 1'b0;
        ticks(6);
        send(OP_RUN_N, 32'd0);
        btn_step = 1'b1;
        ticks(12);
        check("cmd_wins", 32'(pulses.size()), 32'd0);

        // STEP and RUN_FREE during a counted run are ignored.
        pulses.delete();
        send(OP_RUN_N, 32'd4);
        a = cyc;
        ticks(2);
        send(OP_STEP, 32'd0);
        send(OP_RUN_FREE, 32'd0);
        ticks(14);
        check_train("ignore", a, 4);
        exp_cnt = exp_cnt + 32'd4;
        check("ignore_count", cycle_count, exp_cnt);
        check("ignore_state", 32'(ctrl_state), 32'(ST_IDLE));

        // Counter wrap from all-ones.
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count;
        exp_cnt = 32'hFFFF_FFFF;
        send(OP_STEP, 32'd0);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check("wrap", cycle_count, exp_cnt);

        // Randomized runs against the breakpoint rule.
        for (int it = 0; it < 8; it++) begin
            free = 1'(it % 2);
            n    = int'($urandom_range(1, 8));
            be   = free ? 1'b1 : 1'($urandom_range(0, 1));
            k    = free ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 9));
            halt = free || (be && k < n);
            exp_p = halt ? k : n;
            cpu_pc  = 32'd0;
            bp_en   = be;
            bp_addr = 32'(4 * k);
            pulses.delete();
            send(free ? OP_RUN_FREE : OP_RUN_N, 32'(n));
            a = cyc;
            ticks(9 * int'(DIV) + 6);
            check_train("rnd", a, exp_p);
            exp_cnt = exp_cnt + 32'(exp_p);
            check("rnd_count", cycle_count, exp_cnt);
            check("rnd_pc", cpu_pc, 32'(4 * exp_p));
            check("rnd_state", 32'(ctrl_state), halt ? 32'(ST_BP_HALT) : 32'(ST_IDLE));
            check("rnd_bphit", 32'(bp_hit), 32'(halt));
            if (halt) begin
                send(OP_HALT, 32'd0);
                check("rnd_halt_state", 32'(ctrl_state), 32'(ST_IDLE));
                check("rnd_halt_hit", 32'(bp_hit), 32'd0);
            end
            bp_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, is the number of consecutive stable clk samples required to accept a button level.
REQ-002 Parameter RUN_DIV, default 1, is the clk period count between enable pulses in run modes (legal range 1..65535).
REQ-003 clk  in  1  system clock (10 MHz); all logic on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 btn_step  in  1  raw step pushbutton, active-low, asynchronous to clk.
REQ-006 cmd_valid  in  1  one-cycle command strobe.
REQ-007 cmd_op  in  2  command: 0 STEP, 1 RUN_N, 2 RUN_FREE, 3 HALT.
REQ-008 cmd_count  in  32  cycle count for RUN_N; sampled only with cmd_valid.
REQ-009 bp_en  in  1  breakpoint enable.
REQ-010 bp_addr  in  32  breakpoint PC.
REQ-011 cpu_pc  in  32  current CPU PC.
REQ-012 cpu_clk_en  out  1  CE for the CPU clock buffer.
REQ-013 ctrl_state  out  2  current FSM state encoding.
REQ-014 cycle_count  out  32  total enable pulses issued since reset.
REQ-015 bp_hit  out  1  high while halted on a breakpoint.

Function
REQ-016 FSM states: IDLE, RUN_N, RUN_FREE, BP_HALT; cpu_clk_en is registered and never high for two consecutive cycles when RUN_DIV>1.
REQ-017 Step event = cmd_valid with STEP, or the debounced btn_step press (high-to-low), either in IDLE or BP_HALT; it produces exactly one cpu_clk_en pulse on the next cycle and leaves the FSM in IDLE.
REQ-018 RUN_N with cmd_count=0 is a no-op; with N>0 the block enters RUN_N, issues exactly N pulses spaced RUN_DIV cycles apart (first pulse on the cycle after acceptance), then returns to IDLE.
REQ-019 RUN_FREE issues pulses every RUN_DIV cycles indefinitely until HALT or breakpoint.
REQ-020 In RUN_N/RUN_FREE, before every pulse except the first of a run, if bp_en and cpu_pc==bp_addr, no pulse is issued and the FSM enters BP_HALT with bp_hit=1.
REQ-021 HALT from any state returns to IDLE on the next cycle, with no further pulses; an in-flight pulse already registered completes.
REQ-022 STEP/RUN commands arriving during RUN_N or RUN_FREE are ignored; button presses are ignored outside IDLE/BP_HALT.
REQ-023 A cmd_valid and a button event in the same cycle: the command wins and the button event is discarded.
REQ-024 bp_hit clears when any STEP/RUN/HALT is accepted from BP_HALT.
REQ-025 cycle_count increments on each pulse and wraps 0xFFFFFFFF->0.
REQ-026 The debouncer accepts a new btn_step level only after DEBOUNCE_CYCLES identical synchronised samples; a two-flop synchroniser precedes it.

Reset
REQ-027 While resetn=0: cpu_clk_en=1 (combinationally ORed), so the CPU sees clock edges for its synchronous reset.
REQ-028 While resetn=0: state IDLE, cycle_count=0, bp_hit=0, internal counters 0, and the debounced button level released (high).
REQ-029 On reset deassertion, cpu_clk_en drops to 0 within the same cycle; reset asserted mid-run aborts the run immediately.

Structure
REQ-030 FSM state encodings and cmd_op codes live in shared package cpu_step_pkg.
REQ-031 The synchroniser and debouncer form one sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES, with an edge-pulse output.

Verification
REQ-032 Reset held 5 cycles -> cpu_clk_en=1 throughout; after release, cpu_clk_en=0, cycle_count=0, ctrl_state=IDLE.
REQ-033 DEBOUNCE_CYCLES=4: btn_step low for 3 cycles -> no pulse; low for 10 cycles -> exactly one pulse, cycle_count=1.
REQ-034 RUN_DIV=3, RUN_N with cmd_count=5 -> 5 pulses 3 cycles apart, cycle_count=5, then IDLE; cmd_count=0 -> no pulse.
REQ-035 RUN_FREE, bp_en=1, bp_addr=0x0000000C, PC incrementing by 4 from 0 -> pulses until PC=0x0C, then BP_HALT, bp_hit=1, cycle_count=3; STEP -> one pulse, PC=0x10, bp_hit=0.
REQ-036 RUN_FREE, then HALT and btn_step press in the same cycle -> IDLE next cycle, no extra pulse; STEP during RUN_N is ignored.
REQ-037 Preload cycle_count to 0xFFFFFFFF via a forced run -> the next pulse wraps it to 0.
